// File: rtl/mem_read_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_read_arbiter_pkg
// Purpose : Shared constants for the memory read arbiter: FSM state
//           encodings, legal read-latency range and default bus widths.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package mem_read_arbiter_pkg;

  // FSM state encodings
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  // Legal memory read latency range (cycles from mem_en to mem_rdata)
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 4;

  // Wait counter width; holds LAT-1 for the largest legal LAT
  localparam int CNT_W = 2;

  // Default widths: {mem_select, word_addr[6:0]} and 32-bit words
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 32;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter2
// Purpose : Two-request round-robin grant logic with its priority pointer.
//           The pointer names the requester that wins a tie; on update it
//           moves to the requester that did not win the last grant.
// Ports   : clk, rst        - clock, asynchronous active-high reset
//           valid0, valid1  - request inputs
//           ptr_upd         - load the pointer this cycle
//           upd_gid         - id of the requester just served
//           grant0, grant1  - combinational one-hot (or zero) grants
// Revision: 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
  input  logic clk,
  input  logic rst,
  input  logic valid0,
  input  logic valid1,
  input  logic ptr_upd,
  input  logic upd_gid,
  output logic grant0,
  output logic grant1
);

  logic r_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= 1'b0;
    end else if (ptr_upd) begin
      // The requester just served drops to lowest priority
      r_ptr <= ~upd_gid;
    end
  end

  // A lone requester always wins; the pointer only breaks ties
  assign grant0 = valid0 & (~r_ptr | ~valid1);
  assign grant1 = valid1 & ( r_ptr | ~valid0);

endmodule
`default_nettype wire

// File: rtl/mem_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_read_arbiter
// Purpose : Shares one memory read port between two requesters with
//           round-robin arbitration and a single outstanding read.
//           Sequence per read: IDLE (handshake) -> ISSUE (mem_en) ->
//           WAIT (LAT cycles) -> RESP (one-cycle response pulse).
// Ports   : clk, rst                 - clock, asynchronous active-high reset
//           reqN_valid/addr/ready    - request handshake, requester N
//           rspN_valid/data          - response pulse and held data
//           mem_en/mem_addr/mem_rdata- memory read port
//           busy                     - high whenever the FSM is not IDLE
// Revision: 1.0 - initial release
// ============================================================================
module mem_read_arbiter
  import mem_read_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  if (LAT < LAT_MIN || LAT > LAT_MAX) begin : g_lat_check
    $error("mem_read_arbiter: LAT out of range 1..4");
  end

  localparam logic [CNT_W-1:0] c_cnt_init = CNT_W'(LAT - 1);

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic              r_gid;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_rsp0_data;
  logic [DATA_W-1:0] r_rsp1_data;
  logic              w_grant0;
  logic              w_grant1;
  logic              w_hs;
  logic              w_wait_done;

  rr_arbiter2 u_rr (
    .clk     (clk),
    .rst     (rst),
    .valid0  (req0_valid),
    .valid1  (req1_valid),
    .ptr_upd (r_state == RESP),
    .upd_gid (r_gid),
    .grant0  (w_grant0),
    .grant1  (w_grant1)
  );

  // Grants are only honoured in IDLE, so a handshake implies IDLE
  assign w_hs        = (r_state == IDLE) & (w_grant0 | w_grant1);
  assign w_wait_done = (r_state == WAIT) & (r_cnt == '0);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_hs) w_next_state = ISSUE;
      ISSUE:   w_next_state = WAIT;
      WAIT:    if (r_cnt == '0) w_next_state = RESP;
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    mem_en     = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    case (r_state)
      IDLE: begin
        req0_ready = w_grant0;
        req1_ready = w_grant1;
      end
      ISSUE:   mem_en = 1'b1;
      RESP: begin
        rsp0_valid = ~r_gid;
        rsp1_valid =  r_gid;
      end
      default: ;
    endcase
    busy = (r_state != IDLE);
  end

  // Datapath: latched request, latency counter, per-requester read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gid       <= 1'b0;
      r_addr      <= '0;
      r_cnt       <= '0;
      r_rsp0_data <= '0;
      r_rsp1_data <= '0;
    end else begin
      if (w_hs) begin
        r_gid  <= w_grant1;
        r_addr <= w_grant1 ? req1_addr : req0_addr;
      end
      if (r_state == ISSUE) begin
        r_cnt <= c_cnt_init;
      end else if (r_state == WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      // Only the granted requester's data register is ever written
      if (w_wait_done) begin
        if (r_gid) begin
          r_rsp1_data <= mem_rdata;
        end else begin
          r_rsp0_data <= mem_rdata;
        end
      end
    end
  end

  assign mem_addr  = r_addr;
  assign rsp0_data = r_rsp0_data;
  assign rsp1_data = r_rsp1_data;

endmodule
`default_nettype wire

// File: doc/mem_read_arbiter.md
Name: mem_read_arbiter

Overview:
- Shares the single read port of the combined instruction/data memory space between two requesters.
- The memory space is 256 words: addr[7] selects data memory, addr[6:0] selects the word.
- Requester 0 is the display address sequencer. Requester 1 is the debug/dump port.
- Arbitration is round-robin with one outstanding read at a time, a valid/ready request handshake, and a one-cycle response pulse routed back to the granted requester.

Parameters:
- ADDR_W, 8: memory word address width ({mem_select, word_addr}).
- DATA_W, 32: memory read data width.
- LAT, 1: memory read latency in cycles from mem_en to mem_rdata valid. Legal range is 1..4.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- req0_valid  input  1  requester 0 read request.
- req0_addr  input  ADDR_W  requester 0 read address.
- req0_ready  output  1  requester 0 handshake accept.
- rsp0_valid  output  1  requester 0 response pulse.
- rsp0_data  output  DATA_W  requester 0 read data.
- req1_valid, req1_addr, req1_ready, rsp1_valid, rsp1_data: same as requester 0, for requester 1.
- mem_en  output  1  memory read strobe.
- mem_addr  output  ADDR_W  memory read address.
- mem_rdata  input  DATA_W  memory read data.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (asynchronous, rst=1):
  - State = IDLE, priority pointer = 0, wait counter = 0.
  - mem_en=0, mem_addr=0, rsp*_valid=0, rsp*_data=0, busy=0.
  - Reset mid-transaction aborts it: no response is issued and the pointer returns to 0.
- FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - req*_ready is combinational and asserted only in IDLE.
  - req0_ready = valid0 & (ptr==0 | !valid1).
  - req1_ready = valid1 & (ptr==1 | !valid0).
  - At most one ready is high in any cycle.
  - Handshake = valid & ready in cycle T. On the handshake, the winner's addr and a grant id are latched, and the FSM moves to ISSUE.
- ISSUE (T+1):
  - mem_en=1 for exactly one cycle; mem_addr = latched addr.
  - The counter is loaded with LAT-1.
- WAIT (T+2 .. T+1+LAT):
  - mem_addr holds its value; mem_en=0.
  - mem_rdata is captured into the granted requester's rsp_data register at the end of the final WAIT cycle (counter==0).
- RESP (T+2+LAT):
  - The granted requester's rsp_valid=1 for exactly one cycle; the other rsp_valid stays 0.
  - The pointer is set to the other requester (the winner becomes lowest priority).
  - Next state is IDLE.
- Responses have no backpressure; the requester must accept the pulse.
- rspN_data holds its last value until that requester's next response. The non-granted requester's data register is never modified.
- Throughput: one read per LAT+3 cycles. No new handshake is accepted in ISSUE, WAIT or RESP, even if valid is high.
- Requester rule: valid stays high and addr stays stable until ready. The arbiter samples addr only on the handshake cycle.
- Address range: the full ADDR_W range is accepted without a range check. Address 8'hFF is legal.
- Pointer behaviour:
  - If both requesters are valid in IDLE, ptr decides.
  - If only one is valid, it wins regardless of ptr.
  - Back-to-back requests from both requesters therefore alternate strictly 0,1,0,1...
- Width rules: the wait counter is 2 bits, sized for the LAT maximum of 4. There is no arithmetic on addresses or data.

Decomposition:
- Shared package: FSM state localparams (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3), the LAT min/max constants, and the default ADDR_W/DATA_W.
- Sub-module rr_arbiter2:
  - Two-request combinational round-robin grant logic, plus the pointer register with an update enable.
  - Instantiated once inside mem_read_arbiter.

Test Plan:
- Reset, then only req0 with addr=8'h05 and mem model returning 32'hA5A5_0005 (LAT=1) -> req0_ready at T, mem_en at T+1 with mem_addr=8'h05, rsp0_valid one cycle at T+3 with rsp0_data=32'hA5A5_0005, rsp1_valid=0 throughout.
- Both valid continuously, req0 addr=8'h10, req1 addr=8'h90 -> grants alternate 0,1,0,1, period 4 cycles, and mem_addr sequence 10,90,10,90.
- LAT=4 build, req1 addr=8'hFF -> mem_en at T+1, rsp1_valid at T+6 carrying the data presented 4 cycles after mem_en, busy high T+1..T+6.
- req0 raised while req1 is in WAIT -> req0_ready stays 0 until IDLE. Then req0 is granted, and rsp1_data keeps its previous value.
- rst pulsed during WAIT -> outputs 0 immediately (asynchronous), no rsp pulse afterwards, and the next simultaneous request grants req0 (ptr=0).
- Only req1 valid while ptr=0 -> req1 is granted immediately, with no idle cycle.
